// File: rtl/tri_pkg.sv
// Shared definitions for the triangle point collector: grid geometry,
// count width and the controller state encoding.
package tri_pkg;

  localparam int COORD_W_DEF = 3;
  localparam int N_DEF       = 2 ** COORD_W_DEF;
  localparam int CNT_W_DEF   = 2 * COORD_W_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

  // Count must hold N*N, which needs one bit more than 2*COORD_W.
  function automatic int cnt_w(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

endpackage

// File: rtl/tri_point_collector_if.sv
// Upstream point stream, consumer readout and status bundle of the collector.
interface tri_point_collector_if
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);
  localparam int N     = 2 ** COORD_W;
  localparam int CNT_W = cnt_w(COORD_W);

  logic               busy;
  logic               po;
  logic [COORD_W-1:0] xo;
  logic [COORD_W-1:0] yo;
  logic               rd;
  logic               ready;
  logic               row_valid;
  logic [COORD_W-1:0] row_idx;
  logic [N-1:0]       row_bits;
  logic [CNT_W-1:0]   count;
  logic               dup_err;
  logic               drop_err;

  modport master (
    output busy, po, xo, yo, rd,
    input  ready, row_valid, row_idx, row_bits, count, dup_err, drop_err
  );

  modport slave (
    input  busy, po, xo, yo, rd,
    output ready, row_valid, row_idx, row_bits, count, dup_err, drop_err
  );
endinterface

// File: rtl/tri_bitmap.sv
// N x N pixel bitmap: synchronous clear, single-bit set returning the bit's
// previous value, and a combinational row read port.
module tri_bitmap
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    set_en,
  input  logic [COORD_W-1:0]      set_x,
  input  logic [COORD_W-1:0]      set_y,
  output logic                    old_bit,
  input  logic [COORD_W-1:0]      rd_y,
  output logic [(2**COORD_W)-1:0] rd_row
);
  localparam int N = 2 ** COORD_W;

  logic [N-1:0] mem_q [N];
  logic [N-1:0] mem_d [N];
  logic [N-1:0] set_mask_s;

  assign set_mask_s = N'(1) << set_x;
  assign old_bit    = mem_q[set_y][set_x];
  assign rd_row     = mem_q[rd_y];

  // Clear is applied before set, so a clear+set cycle leaves exactly one bit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mem_d[i] = (clr ? '0 : mem_q[i])
               | ((set_en && (set_y == COORD_W'(i))) ? set_mask_s : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/tri_point_collector.sv
// Captures one rasterised triangle into a bitmap, counts distinct pixels and
// streams the bitmap out one row per read request.
module tri_point_collector
  import tri_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  tri_point_collector_if.slave  bus
);
  localparam int N     = 2 ** COORD_W;
  localparam int CNT_W = cnt_w(COORD_W);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(N * N);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(N - 1);

  state_e               state_q, state_d;
  logic                 busy_d_q, busy_d_d;
  logic [COORD_W-1:0]   row_ptr_q, row_ptr_d;
  logic                 ready_q, ready_d;
  logic                 row_valid_q, row_valid_d;
  logic [COORD_W-1:0]   row_idx_q, row_idx_d;
  logic [N-1:0]         row_bits_q, row_bits_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 dup_err_q, dup_err_d;
  logic                 drop_err_q, drop_err_d;

  logic                 busy_rise_s, busy_fall_s;
  logic                 bm_clr_s, bm_set_s, bm_old_s;
  logic [N-1:0]         bm_row_s;

  assign busy_rise_s = bus.busy & ~busy_d_q;
  assign busy_fall_s = ~bus.busy & busy_d_q;

  tri_bitmap #(.COORD_W(COORD_W)) u_bitmap (
    .clk     (clk),
    .reset   (reset),
    .clr     (bm_clr_s),
    .set_en  (bm_set_s),
    .set_x   (bus.xo),
    .set_y   (bus.yo),
    .old_bit (bm_old_s),
    .rd_y    (row_ptr_q),
    .rd_row  (bm_row_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_d_q    <= 1'b0;
      row_ptr_q   <= '0;
      ready_q     <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      row_bits_q  <= '0;
      count_q     <= '0;
      dup_err_q   <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_d_q    <= busy_d_d;
      row_ptr_q   <= row_ptr_d;
      ready_q     <= ready_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      row_bits_q  <= row_bits_d;
      count_q     <= count_d;
      dup_err_q   <= dup_err_d;
      drop_err_q  <= drop_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (busy_rise_s) state_d = ST_COLLECT;
        else             state_d = ST_IDLE;
      end
      ST_COLLECT: begin
        if (busy_fall_s) state_d = ST_FULL;
        else             state_d = ST_COLLECT;
      end
      ST_FULL, ST_READOUT: begin
        if (bus.rd && (row_ptr_q == LAST_ROW)) state_d = ST_IDLE;
        else if (bus.rd)                        state_d = ST_READOUT;
        else                                    state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A busy rise while a bitmap is still held only flags the loss.
  always_comb begin
    busy_d_d    = bus.busy;
    row_ptr_d   = row_ptr_q;
    ready_d     = (state_d == ST_FULL) || (state_d == ST_READOUT);
    row_valid_d = 1'b0;
    row_idx_d   = row_idx_q;
    row_bits_d  = row_bits_q;
    count_d     = count_q;
    dup_err_d   = dup_err_q;
    drop_err_d  = drop_err_q;
    bm_clr_s    = 1'b0;
    bm_set_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (busy_rise_s) begin
          bm_clr_s = 1'b1;
          bm_set_s = bus.po;
          count_d  = bus.po ? CNT_W'(1) : CNT_W'(0);
        end else begin
          bm_clr_s = 1'b0;
        end
      end
      ST_COLLECT: begin
        bm_set_s = bus.po;
        if (bus.po && bm_old_s) begin
          dup_err_d = 1'b1;
        end else if (bus.po && (count_q != CNT_MAX)) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q;
        end
      end
      ST_FULL, ST_READOUT: begin
        if (busy_rise_s) drop_err_d = 1'b1;
        else             drop_err_d = drop_err_q;
        if (bus.rd) begin
          row_valid_d = 1'b1;
          row_idx_d   = row_ptr_q;
          row_bits_d  = bm_row_s;
          row_ptr_d   = row_ptr_q + COORD_W'(1);
        end else begin
          row_valid_d = 1'b0;
        end
      end
      default: begin
        row_ptr_d = '0;
      end
    endcase
  end

  assign bus.ready     = ready_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_idx   = row_idx_q;
  assign bus.row_bits  = row_bits_q;
  assign bus.count     = count_q;
  assign bus.dup_err   = dup_err_q;
  assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_tri_point_collector.sv
// Directed and randomized bench for tri_point_collector against a pixel-set
// reference model (bitmap array, popcount, sticky flags).
module tb_tri_point_collector;
  import tri_pkg::*;

  localparam int CW = 3;
  localparam int NN = 8;

  logic clk = 1'b0;
  logic reset;

  tri_point_collector_if #(.COORD_W(CW)) bus ();

  tri_point_collector #(.COORD_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [NN-1:0] mdl_bits [NN];
  bit collecting, holding, mdl_dup, mdl_drop;
  int ptr;
  logic [NN-1:0] exp_rows [NN];

  function automatic int mdl_count();
    int c = 0;
    for (int y = 0; y < NN; y++)
      for (int x = 0; x < NN; x++)
        c += int'(mdl_bits[y][x]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int y = 0; y < NN; y++) mdl_bits[y] = '0;
    collecting = 0; holding = 0; mdl_dup = 0; mdl_drop = 0; ptr = 0;
  endtask

  task automatic apply(input int x, input int y);
    if (mdl_bits[y][x]) mdl_dup = 1;
    mdl_bits[y][x] = 1'b1;
  endtask

  task automatic chk_status();
    chk("count",    bus.count,    64'(mdl_count()));
    chk("dup_err",  bus.dup_err,  64'(mdl_dup));
    chk("drop_err", bus.drop_err, 64'(mdl_drop));
    chk("ready",    bus.ready,    64'(holding));
  endtask

  task automatic begin_tri(input bit p, input int x, input int y);
    bus.busy = 1'b1; bus.po = p; bus.xo = 3'(x); bus.yo = 3'(y);
    tick();
    bus.po = 1'b0;
    if (holding) mdl_drop = 1;
    else begin
      for (int r = 0; r < NN; r++) mdl_bits[r] = '0;
      collecting = 1;
      if (p) apply(x, y);
    end
    chk_status();
  endtask

  task automatic push(input int x, input int y);
    bus.po = 1'b1; bus.xo = 3'(x); bus.yo = 3'(y);
    tick();
    bus.po = 1'b0;
    if (collecting) apply(x, y);
    chk_status();
  endtask

  task automatic end_tri(input bit p, input int x, input int y);
    bus.busy = 1'b0; bus.po = p; bus.xo = 3'(x); bus.yo = 3'(y);
    tick();
    bus.po = 1'b0;
    if (collecting) begin
      if (p) apply(x, y);
      collecting = 0;
      holding = 1;
    end
    chk_status();
  endtask

  task automatic read_row(input bit r);
    bit exp_v;
    int exp_idx;
    bus.rd = r;
    tick();
    bus.rd = 1'b0;
    exp_v = r && holding;
    exp_idx = ptr;
    if (exp_v) begin
      ptr++;
      if (ptr == NN) begin ptr = 0; holding = 0; end
    end
    chk("row_valid", bus.row_valid, 64'(exp_v));
    if (exp_v) begin
      chk("row_idx",  bus.row_idx,  64'(exp_idx));
      chk("row_bits", bus.row_bits, 64'(mdl_bits[exp_idx]));
    end
    chk_status();
  endtask

  task automatic chk_all_zero();
    chk("rst.ready",     bus.ready,     64'(0));
    chk("rst.row_valid", bus.row_valid, 64'(0));
    chk("rst.row_idx",   bus.row_idx,   64'(0));
    chk("rst.row_bits",  bus.row_bits,  64'(0));
    chk("rst.count",     bus.count,     64'(0));
    chk("rst.dup_err",   bus.dup_err,   64'(0));
    chk("rst.drop_err",  bus.drop_err,  64'(0));
  endtask

  initial begin
    int k, cnt_save;
    bus.busy = 1'b0; bus.po = 1'b0; bus.xo = '0; bus.yo = '0; bus.rd = 1'b0;
    reset = 1'b1;
    mdl_reset();
    #12;
    chk_all_zero();
    tick();
    reset = 1'b0;
    tick();

    // Right triangle (1,1),(4,1),(1,4): first pixel in the rise cycle.
    exp_rows = '{8'h00, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00, 8'h00, 8'h00};
    begin_tri(1'b1, 1, 1);
    push(2, 1); push(3, 1); push(4, 1);
    push(1, 2); push(2, 2); push(3, 2);
    push(1, 3); push(2, 3);
    push(1, 4);
    end_tri(1'b0, 0, 0);
    chk("t34.count", bus.count, 64'(10));
    chk("t34.ready", bus.ready, 64'(1));
    for (int i = 0; i < NN; i++) begin
      read_row(1'b1);
      chk("t34.row", bus.row_bits, 64'(exp_rows[i]));
    end
    chk("t35.ready_low", bus.ready, 64'(0));
    read_row(1'b0);
    push(5, 5);
    chk("t25.count_hold", bus.count, 64'(10));

    // Duplicate pixel (3,3), then a clean triangle keeps dup_err.
    begin_tri(1'b0, 0, 0);
    push(3, 3); push(3, 3);
    end_tri(1'b0, 0, 0);
    chk("t36.count", bus.count, 64'(1));
    chk("t36.dup", bus.dup_err, 64'(1));
    for (int i = 0; i < NN; i++) read_row(1'b1);
    begin_tri(1'b1, 0, 0);
    push(1, 0); push(6, 3);
    end_tri(1'b0, 0, 0);
    chk("t36.dup_sticky", bus.dup_err, 64'(1));
    for (int i = 0; i < NN; i++) read_row(1'b1);

    // Busy rise while a bitmap is held is dropped.
    begin_tri(1'b1, 2, 2);
    push(5, 6); push(7, 0);
    end_tri(1'b1, 0, 7);
    cnt_save = mdl_count();
    begin_tri(1'b1, 4, 4);
    push(3, 1);
    end_tri(1'b1, 6, 6);
    chk("t37.drop", bus.drop_err, 64'(1));
    chk("t37.count", bus.count, 64'(cnt_save));
    for (int i = 0; i < NN; i++) read_row(1'b1);

    // Reset in the middle of readout.
    begin_tri(1'b1, 0, 0);
    push(3, 4); push(7, 2);
    end_tri(1'b0, 0, 0);
    read_row(1'b1); read_row(1'b1); read_row(1'b1);
    reset = 1'b1;
    #2;
    chk_all_zero();
    mdl_reset();
    tick();
    reset = 1'b0;
    tick();
    begin_tri(1'b1, 6, 1);
    push(6, 2);
    end_tri(1'b0, 0, 0);
    chk("t38.count", bus.count, 64'(2));
    for (int i = 0; i < NN; i++) read_row(1'b1);

    // Pixel (7,7) in the fall cycle; rd with a gap.
    begin_tri(1'b0, 0, 0);
    push(2, 5);
    end_tri(1'b1, 7, 7);
    chk("t39.count", bus.count, 64'(2));
    read_row(1'b1);
    chk("t39.idx0", bus.row_idx, 64'(0));
    read_row(1'b0);
    chk("t39.gap", bus.row_valid, 64'(0));
    read_row(1'b1);
    chk("t39.idx1", bus.row_idx, 64'(1));
    for (int i = 2; i < NN; i++) read_row(1'b1);
    chk("t39.bit77", bus.row_bits[7], 64'(1));

    // Randomized triangles with random read gaps and occasional drops.
    for (int t = 0; t < 8; t++) begin
      begin_tri(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
      k = $urandom_range(3, 24);
      for (int j = 0; j < k; j++) push($urandom_range(0, 7), $urandom_range(0, 7));
      end_tri(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        begin_tri(1'b1, $urandom_range(0, 7), $urandom_range(0, 7));
        end_tri(1'b0, 0, 0);
      end
      for (int c = 0; c < 200 && holding; c++) read_row(1'($urandom_range(0, 1)));
      chk("rand.drained", bus.ready, 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
